ctrl_sequencer: RTL and testbench
=================================

// Module: ctrl_sequencer
// PURPOSE
//  Multi-cycle control unit directly upstream of the 16-bit datapath.
//  Fetches instruction words over a valid/req handshake and holds them in the ISR.
//  Decodes each instruction into the datapath controls: regw, memw, memin, sflag, spi, pcin, pci, pc_en.
//  Sequences two-phase stack/branch ops (CALL, RET) and halts on HALT or fetch timeout.
// PARAMETERS
//  ISR_W     16  instruction word width
//  WAIT_MAX  15  max cycles FETCH waits for instr_valid before fault; counter is 4 bits
// PORTS
//  clk          in   1   single clock, all state on rising edge
//  reset        in   1   asynchronous, active-low; 0 forces reset state immediately
//  instr_in     in   16  instruction word from instruction memory
//  instr_valid  in   1   instr_in valid this cycle
//  instr_req    out  1   sequencer ready to accept an instruction (FETCH state)
//  isr          out  16  latched instruction to datapath
//  regw         out  1   register-bank write
//  memw         out  1   data-memory write
//  memin        out  2   mem write source: 0 reg x, 1 pc, 2 sign-ext imm
//  sflag        out  1   status-flag update
//  spi          out  2   SP control: 0 hold, 1 inc, 2 dec
//  pcin         out  1   PC source: 0 mem out (y), 1 incrementer path
//  pci          out  1   1 = conditional PC-relative branch
//  pc_en        out  1   PC load enable; PC holds when 0
//  halted       out  1   in HALT state
//  fault        out  1   sticky, set on fetch timeout
// BEHAVIOUR
//  Reset values: state IDLE; isr=0; wait_cnt=0; fault=0; all other outputs 0.
//  All control outputs are Moore outputs, decoded from state + isr. They are 0 outside EXEC/EXEC2.
//  States and transitions:
//   IDLE  -> FETCH after one cycle (reset-release settle).
//   FETCH: instr_req=1. On instr_valid, latch isr<=instr_in, clear wait_cnt, go EXEC.
//          Otherwise wait_cnt++. When wait_cnt==WAIT_MAX with no valid: fault<=1, go HALT.
//   EXEC:  drive phase-1 controls, then go EXEC2 (CALL/RET), HALT (HALT op), or FETCH (all others).
//   EXEC2: drive phase-2 controls, then go FETCH.
//   HALT:  absorbing; all controls 0, halted=1. Left only by reset.
//  Decode by isr[15:14] (class):
//   00 ALU, funsel=isr[13:11]: regw=1, sflag=1, pcin=1, pc_en=1.
//      Exception: funsel 0 is a NOP with pcin=1, pc_en=1 only.
//   01 BRANCH: pci=1, pcin=1, pc_en=1. Condition select is carried in isr.
//   10 STACK, sub-op isr[13:12]:
//      00 PUSH: memin=0, memw=1, spi=2, pcin=1, pc_en=1.
//      01 POP:  regw=1, spi=1, pcin=1, pc_en=1.
//      10 CALL: EXEC memin=1, memw=1, spi=2, pc_en=0. EXEC2 pci=1, pcin=1, pc_en=1.
//      11 RET:  EXEC spi=1, pc_en=0. EXEC2 pcin=0, pc_en=1.
//   11 SYS: isr[13:11]==3'b111 is HALT (EXEC drives all 0, then HALT). Other codes are NOPs as above.
//  Latency: fetch accepted at edge N -> EXEC in cycle N+1 -> instr_req back high in cycle N+2.
//   Single-phase ops take 2 cycles; CALL/RET take 3.
//  instr_valid outside FETCH is ignored; no word is dropped or double-latched.
//  instr_valid arriving in the same cycle wait_cnt reaches WAIT_MAX is accepted; no fault.
//  Reset asserted mid-EXEC2 means the second phase is abandoned and outputs go to 0 asynchronously.
//  spi never takes value 3; an illegal encoding is treated as 0.
// CONFIGURATION
//  CTRL_PERF_CNT_EN defined: adds output retired[15:0].
//   Increments on each EXEC->FETCH or EXEC2->FETCH transition; wraps 0xFFFF->0; reset 0.
//   HALT itself is not counted.
//  CTRL_PERF_CNT_EN undefined: no port, no counter, otherwise identical.
// STRUCTURE
//  Shared package ctrl_pkg holds: state encoding (IDLE, FETCH, EXEC, EXEC2, HALT),
//   class/sub-op codes, SPI_HOLD/INC/DEC, MEMIN_X/PC/IMM.
//  Sub-module ctrl_decode: pure combinational isr + phase -> control word.
//   The FSM, handshake, timeout counter and perf counter stay in ctrl_sequencer.
// TESTING
//  Reset low mid-run -> all outputs 0 immediately. Release -> IDLE one cycle, then instr_req=1.
//  ALU 0x1500 (class 00, funsel 2) with valid -> next cycle regw=1, sflag=1, pcin=1, pc_en=1;
//   following cycle instr_req=1.
//  CALL 0xA000 -> EXEC: memin=1, memw=1, spi=2, pc_en=0. EXEC2: pci=1, pcin=1, pc_en=1.
//   RET 0xB000 -> EXEC: spi=1. EXEC2: pcin=0, pc_en=1.
//  Hold instr_valid=0 for 16 cycles in FETCH -> fault=1, halted=1, instr_req=0; later valid ignored.
//  Valid on the 15th wait cycle -> accepted, fault stays 0. HALT 0xF800 -> halted=1 until reset.
//  With CTRL_PERF_CNT_EN: run 5 ALU ops + 1 CALL -> retired=6.
//   Preload 0xFFFF, one more op -> retired=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the control sequencer.
// States, opcode classes, SP/memin selects and the control word.
package ctrl_pkg;

  localparam int ISR_W_DEF    = 16;
  localparam int WAIT_MAX_DEF = 15;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_EXEC2 = 3'd3,
    ST_HALT  = 3'd4
  } state_e;

  localparam logic [1:0] CLS_ALU = 2'b00;
  localparam logic [1:0] CLS_BR  = 2'b01;
  localparam logic [1:0] CLS_STK = 2'b10;
  localparam logic [1:0] CLS_SYS = 2'b11;

  localparam logic [1:0] SUB_PUSH = 2'b00;
  localparam logic [1:0] SUB_POP  = 2'b01;
  localparam logic [1:0] SUB_CALL = 2'b10;
  localparam logic [1:0] SUB_RET  = 2'b11;

  localparam logic [2:0] SYS_HALT = 3'b111;

  localparam logic [1:0] SPI_HOLD = 2'd0;
  localparam logic [1:0] SPI_INC  = 2'd1;
  localparam logic [1:0] SPI_DEC  = 2'd2;

  localparam logic [1:0] MEMIN_X   = 2'd0;
  localparam logic [1:0] MEMIN_PC  = 2'd1;
  localparam logic [1:0] MEMIN_IMM = 2'd2;

  typedef struct packed {
    logic       regw;
    logic       memw;
    logic [1:0] memin;
    logic       sflag;
    logic [1:0] spi;
    logic       pcin;
    logic       pci;
    logic       pc_en;
  } ctrl_t;

  // op = isr[15:11]: class in [4:3], funsel/sub-op in [2:0]
  function automatic logic is_two_phase(logic [4:0] op);
    return (op[4:3] == CLS_STK) && op[2];
  endfunction

  function automatic logic is_halt(logic [4:0] op);
    return (op[4:3] == CLS_SYS) && (op[2:0] == SYS_HALT);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational decode of opcode bits + phase into the control word.
// Outputs are all zero unless one of the exec phases is active.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [4:0] op_i,
  input  logic       exec_i,
  input  logic       exec2_i,
  output ctrl_t      ctrl_o
);

  logic [1:0] cls;
  logic [1:0] sub;
  logic [2:0] fun;
  ctrl_t      c;

  assign cls = op_i[4:3];
  assign sub = op_i[2:1];
  assign fun = op_i[2:0];

  // Phase-1 controls in EXEC, phase-2 controls in EXEC2
  always_comb begin
    c = '0;
    if (exec_i) begin
      unique case (1'b1)
        cls == CLS_ALU: begin
          c.pcin  = 1'b1;
          c.pc_en = 1'b1;
          if (fun != 3'd0) begin
            c.regw  = 1'b1;
            c.sflag = 1'b1;
          end
        end
        cls == CLS_BR: begin
          c.pci   = 1'b1;
          c.pcin  = 1'b1;
          c.pc_en = 1'b1;
        end
        cls == CLS_STK: begin
          unique case (sub)
            SUB_PUSH: begin
              c.memin = MEMIN_X;
              c.memw  = 1'b1;
              c.spi   = SPI_DEC;
              c.pcin  = 1'b1;
              c.pc_en = 1'b1;
            end
            SUB_POP: begin
              c.regw  = 1'b1;
              c.spi   = SPI_INC;
              c.pcin  = 1'b1;
              c.pc_en = 1'b1;
            end
            SUB_CALL: begin
              c.memin = MEMIN_PC;
              c.memw  = 1'b1;
              c.spi   = SPI_DEC;
            end
            SUB_RET: begin
              c.spi   = SPI_INC;
            end
            default: ;
          endcase
        end
        cls == CLS_SYS: begin
          if (fun != SYS_HALT) begin
            c.pcin  = 1'b1;
            c.pc_en = 1'b1;
          end
        end
        default: ;
      endcase
    end else if (exec2_i && cls == CLS_STK) begin
      if (sub == SUB_CALL) begin
        c.pci   = 1'b1;
        c.pcin  = 1'b1;
        c.pc_en = 1'b1;
      end else if (sub == SUB_RET) begin
        c.pcin  = 1'b0;
        c.pc_en = 1'b1;
      end
    end
    if (c.spi == 2'b11) c.spi = SPI_HOLD;
  end

  assign ctrl_o = c;

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle fetch/exec control sequencer for the 16-bit datapath.
// Optional retired-instruction counter: define CTRL_PERF_CNT_EN.
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int ISR_W    = ISR_W_DEF,
  parameter int WAIT_MAX = WAIT_MAX_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ISR_W-1:0] instr_in,
  input  logic             instr_valid,
  output logic             instr_req,
  output logic [ISR_W-1:0] isr,
  output logic             regw,
  output logic             memw,
  output logic [1:0]       memin,
  output logic             sflag,
  output logic [1:0]       spi,
  output logic             pcin,
  output logic             pci,
  output logic             pc_en,
  output logic             halted,
`ifdef CTRL_PERF_CNT_EN
  output logic [15:0]      retired,
`endif
  output logic             fault
);

  localparam logic [3:0] WMAX = 4'(WAIT_MAX);

  state_e           state_q, state_d;
  logic [ISR_W-1:0] isr_q, isr_d;
  logic [3:0]       wait_q, wait_d;
  logic             fault_q, fault_d;
  logic [4:0]       op;
  ctrl_t            ctrl;

  assign op = isr_q[ISR_W-1 -: 5];

  // State, instruction, timeout and fault registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      isr_q   <= '0;
      wait_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      isr_q   <= isr_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
    end
  end

  // Next-state: fetch handshake, timeout and exec phase sequencing
  always_comb begin
    state_d = state_q;
    isr_d   = isr_q;
    wait_d  = wait_q;
    fault_d = fault_q;
    unique case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (instr_valid) begin
          isr_d   = instr_in;
          wait_d  = '0;
          state_d = ST_EXEC;
        end else if (wait_q == WMAX) begin
          fault_d = 1'b1;
          state_d = ST_HALT;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      ST_EXEC: begin
        if (is_two_phase(op))  state_d = ST_EXEC2;
        else if (is_halt(op))  state_d = ST_HALT;
        else                   state_d = ST_FETCH;
      end
      ST_EXEC2: state_d = ST_FETCH;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_IDLE;
    endcase
  end

  ctrl_decode u_dec (
    .op_i    (op),
    .exec_i  (state_q == ST_EXEC),
    .exec2_i (state_q == ST_EXEC2),
    .ctrl_o  (ctrl)
  );

  assign instr_req = (state_q == ST_FETCH);
  assign halted    = (state_q == ST_HALT);
  assign fault     = fault_q;
  assign isr       = isr_q;
  assign regw      = ctrl.regw;
  assign memw      = ctrl.memw;
  assign memin     = ctrl.memin;
  assign sflag     = ctrl.sflag;
  assign spi       = ctrl.spi;
  assign pcin      = ctrl.pcin;
  assign pci       = ctrl.pci;
  assign pc_en     = ctrl.pc_en;

`ifdef CTRL_PERF_CNT_EN
  logic [15:0] ret_q, ret_d;
  logic        retire;

  assign retire = (state_d == ST_FETCH) &&
                  (state_q == ST_EXEC || state_q == ST_EXEC2);

  // Retired-instruction count, wraps at 16 bits
  always_comb begin
    ret_d = ret_q;
    if (retire) ret_d = ret_q + 16'd1;
  end

  // Retired counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ret_q <= '0;
    else        ret_q <= ret_d;
  end

  assign retired = ret_q;
`endif

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed table-driven bench for ctrl_sequencer.
// Optional retired checks when CTRL_PERF_CNT_EN is defined.
module tb_ctrl_sequencer;

  logic        clk;
  logic        reset;
  logic [15:0] instr_in;
  logic        instr_valid;
  logic        instr_req;
  logic [15:0] isr;
  logic        regw, memw, sflag, pcin, pci, pc_en;
  logic [1:0]  memin, spi;
  logic        halted, fault;
`ifdef CTRL_PERF_CNT_EN
  logic [15:0] retired;
`endif

  int checks = 0;
  int errors = 0;

  ctrl_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .instr_in    (instr_in),
    .instr_valid (instr_valid),
    .instr_req   (instr_req),
    .isr         (isr),
    .regw        (regw),
    .memw        (memw),
    .memin       (memin),
    .sflag       (sflag),
    .spi         (spi),
    .pcin        (pcin),
    .pci         (pci),
    .pc_en       (pc_en),
    .halted      (halted),
`ifdef CTRL_PERF_CNT_EN
    .retired     (retired),
`endif
    .fault       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [15:0] instr;
    logic        req;
    logic        hlt;
    logic        flt;
    logic [15:0] isr;
    logic [9:0]  ctl;
  } vec_t;

  vec_t vecs[$];

  // ctl bits: regw memw memin[1:0] sflag spi[1:0] pcin pci pc_en
  function automatic logic [9:0] mk(
    logic rw, logic mw, logic [1:0] mi, logic sf,
    logic [1:0] sp, logic pn, logic pi, logic pe);
    return {rw, mw, mi, sf, sp, pn, pi, pe};
  endfunction

  function automatic logic [28:0] pack(
    logic rq, logic h, logic f, logic [15:0] i, logic [9:0] c);
    return {rq, h, f, i, c};
  endfunction

  function automatic logic [28:0] act();
    return pack(instr_req, halted, fault, isr,
      mk(regw, memw, memin, sflag, spi, pcin, pci, pc_en));
  endfunction

  task automatic add(logic v, logic [15:0] ins, logic rq,
    logic h, logic f, logic [15:0] i, logic [9:0] c);
    vec_t e;
    e.valid = v; e.instr = ins; e.req = rq;
    e.hlt = h; e.flt = f; e.isr = i; e.ctl = c;
    vecs.push_back(e);
  endtask

  task automatic chk(string name, logic [28:0] exp);
    logic [28:0] a;
    a = act();
    checks++;
    if (a !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, a, exp);
    end
  endtask

  task automatic step(logic v, logic [15:0] ins);
    instr_valid = v;
    instr_in    = ins;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    instr_valid = 1'b0;
    instr_in = '0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  localparam logic [9:0] Z = 10'd0;

  initial begin
    logic [9:0] c_alu, c_nop, c_call1, c_call2, c_ret1, c_ret2;
    logic [9:0] c_br, c_push, c_pop;
    c_alu   = mk(1, 0, 2'd0, 1, 2'd0, 1, 0, 1);
    c_nop   = mk(0, 0, 2'd0, 0, 2'd0, 1, 0, 1);
    c_call1 = mk(0, 1, 2'd1, 0, 2'd2, 0, 0, 0);
    c_call2 = mk(0, 0, 2'd0, 0, 2'd0, 1, 1, 1);
    c_ret1  = mk(0, 0, 2'd0, 0, 2'd1, 0, 0, 0);
    c_ret2  = mk(0, 0, 2'd0, 0, 2'd0, 0, 0, 1);
    c_br    = mk(0, 0, 2'd0, 0, 2'd0, 1, 1, 1);
    c_push  = mk(0, 1, 2'd0, 0, 2'd2, 1, 0, 1);
    c_pop   = mk(1, 0, 2'd0, 0, 2'd1, 1, 0, 1);

    // valid, instr, req, halted, fault, isr, ctl (state seen this cycle)
    add(1, 16'h1234, 0, 0, 0, 16'h0000, Z);
    add(1, 16'h1500, 1, 0, 0, 16'h0000, Z);
    add(1, 16'hA000, 0, 0, 0, 16'h1500, c_alu);
    add(1, 16'hA000, 1, 0, 0, 16'h1500, Z);
    add(1, 16'h9000, 0, 0, 0, 16'hA000, c_call1);
    add(1, 16'h9000, 0, 0, 0, 16'hA000, c_call2);
    add(1, 16'hB000, 1, 0, 0, 16'hA000, Z);
    add(0, 16'h0000, 0, 0, 0, 16'hB000, c_ret1);
    add(0, 16'h0000, 0, 0, 0, 16'hB000, c_ret2);
    add(1, 16'h0000, 1, 0, 0, 16'hB000, Z);
    add(0, 16'h0000, 0, 0, 0, 16'h0000, c_nop);
    add(1, 16'h4123, 1, 0, 0, 16'h0000, Z);
    add(0, 16'h0000, 0, 0, 0, 16'h4123, c_br);
    add(1, 16'h8000, 1, 0, 0, 16'h4123, Z);
    add(0, 16'h0000, 0, 0, 0, 16'h8000, c_push);
    add(1, 16'h9000, 1, 0, 0, 16'h8000, Z);
    add(0, 16'h0000, 0, 0, 0, 16'h9000, c_pop);
    add(1, 16'hC000, 1, 0, 0, 16'h9000, Z);
    add(0, 16'h0000, 0, 0, 0, 16'hC000, c_nop);
    add(1, 16'hF800, 1, 0, 0, 16'hC000, Z);
    add(1, 16'h1500, 0, 0, 0, 16'hF800, Z);
    add(1, 16'h1500, 0, 1, 0, 16'hF800, Z);
    add(0, 16'h0000, 0, 1, 0, 16'hF800, Z);

    reset = 1'b0;
    instr_valid = 1'b0;
    instr_in = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_state", pack(0, 0, 0, 16'h0, Z));
    reset = 1'b1;

    foreach (vecs[i]) begin
      chk($sformatf("vec%0d", i),
        pack(vecs[i].req, vecs[i].hlt, vecs[i].flt,
             vecs[i].isr, vecs[i].ctl));
      step(vecs[i].valid, vecs[i].instr);
    end

    // Reset mid-EXEC2: outputs drop asynchronously
    do_reset();
    step(0, 16'h0);
    step(1, 16'hA000);
    step(0, 16'h0);
    chk("call_exec2", pack(0, 0, 0, 16'hA000, c_call2));
    @(posedge clk);
    #2 reset = 1'b0;
    #1 chk("async_reset", pack(0, 0, 0, 16'h0, Z));
    @(negedge clk);
    reset = 1'b1;
    chk("post_rst_idle", pack(0, 0, 0, 16'h0, Z));
    step(0, 16'h0);
    chk("post_rst_fetch", pack(1, 0, 0, 16'h0, Z));

    // Timeout: 16 FETCH cycles with no valid
    do_reset();
    step(0, 16'h0);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("wait_req%0d", k), pack(1, 0, 0, 16'h0, Z));
      step(0, 16'h0);
    end
    chk("timeout", pack(0, 1, 1, 16'h0, Z));
    step(1, 16'h1500);
    step(1, 16'h1500);
    chk("timeout_sticky", pack(0, 1, 1, 16'h0, Z));
    do_reset();
    chk("fault_cleared", pack(0, 0, 0, 16'h0, Z));

    // Valid arriving when the wait counter is at its limit
    step(0, 16'h0);
    for (int k = 0; k < 15; k++) step(0, 16'h0);
    chk("edge_wait", pack(1, 0, 0, 16'h0, Z));
    step(1, 16'h1500);
    chk("edge_accept", pack(0, 0, 0, 16'h1500, c_alu));
    step(0, 16'h0);
    chk("edge_refetch", pack(1, 0, 0, 16'h1500, Z));

`ifdef CTRL_PERF_CNT_EN
    do_reset();
    checks++;
    if (retired !== 16'd0) begin
      errors++;
      $display("FAIL retired_reset: got %0d expected 0", retired);
    end
    step(0, 16'h0);
    for (int k = 0; k < 5; k++) begin
      step(1, 16'h1500);
      step(0, 16'h0);
    end
    step(1, 16'hA000);
    step(0, 16'h0);
    step(0, 16'h0);
    checks++;
    if (retired !== 16'd6) begin
      errors++;
      $display("FAIL retired_count: got %0d expected 6", retired);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
